// File: rtl/dma_bus_arbiter_pkg.sv
// Shared types and defaults for the DMA bus arbiter: FSM state encoding,
// port-owner encoding, default widths and a saturating counter helper.
package dma_bus_arbiter_pkg;

    localparam int DEF_AW          = 32;
    localparam int DEF_DW          = 32;
    localparam int DEF_TIMEOUT_CYC = 4096;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_GRANT   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

endpackage

// File: rtl/dma_bus_arbiter_if.sv
// Bus bundle between the CPU, the coprocessor DMA, the shared memory port
// and the arbiter. The arbiter uses the slave view; the environment driving
// requests and the memory uses the master view.
interface dma_bus_arbiter_if
    import dma_bus_arbiter_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    // CPU side
    logic          cpu_busy;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wd;
    logic [DW-1:0] cpu_rd;
    logic          cpu_stall;
    // DMA side
    logic          dma_hold;
    logic          dma_hold_ack;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wd;
    logic [DW-1:0] dma_rd;
    // Shared memory port
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;
    // Status
    logic          err_clr;
    logic          timeout_err;
    logic [15:0]   grant_cnt;

    modport slave (
        input  cpu_busy, cpu_we, cpu_addr, cpu_wd,
        output cpu_rd, cpu_stall,
        input  dma_hold, dma_we, dma_addr, dma_wd,
        output dma_hold_ack, dma_rd,
        output mem_we, mem_addr, mem_wd,
        input  mem_rd,
        input  err_clr,
        output timeout_err, grant_cnt
    );

    modport master (
        output cpu_busy, cpu_we, cpu_addr, cpu_wd,
        input  cpu_rd, cpu_stall,
        output dma_hold, dma_we, dma_addr, dma_wd,
        input  dma_hold_ack, dma_rd,
        input  mem_we, mem_addr, mem_wd,
        output mem_rd,
        output err_clr,
        input  timeout_err, grant_cnt
    );

endinterface

// File: rtl/dma_bus_arbiter_wdog.sv
// Grant watchdog: counts consecutive cycles spent in GRANT and flags the
// last allowed one. Only instantiated when DMA_BUS_ARBITER_TIMEOUT_EN is
// defined.
module dma_bus_arbiter_wdog #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic grant_i,
    output logic expire_o
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count while granted, restart from zero whenever the grant is absent.
    // The arbiter leaves GRANT on expiry, so the count never runs past the limit.
    always_comb begin
        cnt_d = grant_i ? cnt_q + CW'(1) : '0;
    end

    // Counter register with asynchronous reset.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // The TIMEOUT_CYC-th consecutive GRANT cycle is the last one.
    assign expire_o = grant_i && (cnt_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/dma_bus_arbiter.sv
// Shared memory port arbiter between the CPU and a coprocessor DMA.
// The CPU owns the port by default; a DMA request stalls the CPU, waits for
// its in-flight access to drain, then hands the port to the DMA.
// Optional feature: define DMA_BUS_ARBITER_TIMEOUT_EN to revoke grants that
// last TIMEOUT_CYC cycles and report them through a sticky timeout_err.
module dma_bus_arbiter
    import dma_bus_arbiter_pkg::*;
#(
    parameter int AW          = DEF_AW,
    parameter int DW          = DEF_DW,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic           clk,
    input  logic           rst,
    dma_bus_arbiter_if.slave bus
);
    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    logic        ack_q,   ack_d;
    logic        stall_q, stall_d;
    logic [15:0] cnt_q,   cnt_d;
    logic        expire;

    logic          mux_we;
    logic [AW-1:0] mux_addr;
    logic [DW-1:0] mux_wd;
    logic [DW-1:0] mux_cpu_rd;
    logic [DW-1:0] mux_dma_rd;

`ifdef DMA_BUS_ARBITER_TIMEOUT_EN
    logic err_q, err_d;

    dma_bus_arbiter_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .grant_i  (state_q == ST_GRANT),
        .expire_o (expire)
    );

    // Sticky error: a revocation in the same cycle as err_clr keeps the flag set.
    always_comb begin
        err_d = bus.err_clr ? 1'b0 : err_q;
        if (state_q == ST_GRANT && state_d == ST_LOCKOUT) err_d = 1'b1;
    end

    // Error flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign bus.timeout_err = err_q;
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
    logic unused_err_clr;

    assign unused_err_clr  = bus.err_clr;
    assign expire          = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    // Next state and registered outputs, all derived from the next state.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (bus.dma_hold) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (!bus.dma_hold)      state_d = ST_IDLE;
                else if (!bus.cpu_busy) state_d = ST_GRANT;
            end
            ST_GRANT: begin
                if (expire)             state_d = ST_LOCKOUT;
                else if (!bus.dma_hold) state_d = ST_RELEASE;
            end
            ST_RELEASE: state_d = ST_IDLE;
            ST_LOCKOUT: if (!bus.dma_hold) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        ack_d   = (state_d == ST_GRANT);
        owner_d = (state_d == ST_GRANT) ? OWN_DMA : OWN_CPU;
        stall_d = (state_d == ST_DRAIN) || (state_d == ST_GRANT) ||
                  (state_d == ST_RELEASE);
        cnt_d   = (state_q == ST_GRANT && state_d == ST_RELEASE) ?
                  sat_inc16(cnt_q) : cnt_q;
    end

    // FSM state and output registers; reset returns the port to the CPU at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_CPU;
            ack_q   <= 1'b0;
            stall_q <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ack_q   <= ack_d;
            stall_q <= stall_d;
            cnt_q   <= cnt_d;
        end
    end

    // Port mux driven by the registered owner; write enables are gated so the
    // CPU writes only in IDLE and the DMA only in GRANT.
    always_comb begin
        if (owner_q == OWN_DMA) begin
            mux_we     = bus.dma_we && (state_q == ST_GRANT);
            mux_addr   = bus.dma_addr;
            mux_wd     = bus.dma_wd;
            mux_cpu_rd = '0;
            mux_dma_rd = bus.mem_rd;
        end else begin
            mux_we     = bus.cpu_we && (state_q == ST_IDLE);
            mux_addr   = bus.cpu_addr;
            mux_wd     = bus.cpu_wd;
            mux_cpu_rd = bus.mem_rd;
            mux_dma_rd = '0;
        end
    end

    assign bus.mem_we       = mux_we;
    assign bus.mem_addr     = mux_addr;
    assign bus.mem_wd       = mux_wd;
    assign bus.cpu_rd       = mux_cpu_rd;
    assign bus.dma_rd       = mux_dma_rd;
    assign bus.dma_hold_ack = ack_q;
    assign bus.cpu_stall    = stall_q;
    assign bus.grant_cnt    = cnt_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed self-checking bench for dma_bus_arbiter. Covers reset, basic
// grant, drain, abort, asynchronous reset mid-grant, back-to-back requests
// and long holds (timeout behaviour when DMA_BUS_ARBITER_TIMEOUT_EN is set).
module tb_dma_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    dma_bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dma_bus_arbiter #(
        .AW          (AW),
        .DW          (DW),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_ack;
        logic exp_err;
        n_cmp = 0;
        n_err = 0;

        bus.cpu_busy = 1'b0; bus.cpu_we  = 1'b0; bus.cpu_addr = '0; bus.cpu_wd = '0;
        bus.dma_hold = 1'b0; bus.dma_we  = 1'b0; bus.dma_addr = '0; bus.dma_wd = '0;
        bus.mem_rd   = 32'h1234_5678;
        bus.err_clr  = 1'b0;

        // ---------------- reset ----------------
        rst = 1'b1;
        repeat (2) tick();
        check("rst_ack",   bus.dma_hold_ack, 0);
        check("rst_stall", bus.cpu_stall,    0);
        check("rst_cnt",   bus.grant_cnt,    0);
        check("rst_err",   bus.timeout_err,  0);
        rst = 1'b0;
        tick();

        // ---------------- basic grant ----------------
        bus.cpu_we = 1'b1; bus.cpu_addr = 32'h40; bus.cpu_wd = 32'h5555_AAAA;
        #1;
        check("idle_mem_we",   bus.mem_we,   1);
        check("idle_mem_addr", bus.mem_addr, 32'h40);
        check("idle_cpu_rd",   bus.cpu_rd,   32'h1234_5678);
        check("idle_dma_rd",   bus.dma_rd,   0);
        bus.dma_hold = 1'b1;                  // cycle 0
        tick();                               // cycle 1
        check("basic_c1_stall", bus.cpu_stall,    1);
        check("basic_c1_ack",   bus.dma_hold_ack, 0);
        check("basic_c1_we",    bus.mem_we,       0);
        tick();                               // cycle 2
        check("basic_c2_ack",   bus.dma_hold_ack, 1);
        bus.dma_we = 1'b1; bus.dma_addr = 32'h100; bus.dma_wd = 32'hDEAD_BEEF;
        bus.mem_rd = 32'hCAFE_F00D;
        #1;
        check("basic_mem_we",   bus.mem_we,   1);
        check("basic_mem_addr", bus.mem_addr, 32'h100);
        check("basic_mem_wd",   bus.mem_wd,   32'hDEAD_BEEF);
        check("basic_dma_rd",   bus.dma_rd,   32'hCAFE_F00D);
        check("basic_cpu_rd",   bus.cpu_rd,   0);
        bus.dma_hold = 1'b0;
        tick();                               // RELEASE
        check("basic_rel_ack",   bus.dma_hold_ack, 0);
        check("basic_rel_stall", bus.cpu_stall,    1);
        check("basic_rel_we",    bus.mem_we,       0);
        tick();                               // IDLE
        check("basic_idle_stall", bus.cpu_stall, 0);
        check("basic_cnt",        bus.grant_cnt, 1);
        bus.dma_we = 1'b0;

        // ---------------- drain ----------------
        bus.cpu_busy = 1'b1; bus.cpu_we = 1'b1;
        bus.dma_hold = 1'b1;                  // cycle 0
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("drain_ack",   bus.dma_hold_ack, 0);
            check("drain_stall", bus.cpu_stall,    1);
            check("drain_we",    bus.mem_we,       0);
            if (i == 5) bus.cpu_busy = 1'b0;  // busy falls at cycle 5
        end
        tick();                               // cycle 6
        check("drain_ack_rise", bus.dma_hold_ack, 1);
        bus.dma_hold = 1'b0; bus.cpu_we = 1'b0;
        tick();
        tick();
        check("drain_cnt", bus.grant_cnt, 2);

        // ---------------- abort ----------------
        bus.cpu_busy = 1'b1;
        bus.dma_hold = 1'b1;
        tick();
        check("abort_stall", bus.cpu_stall, 1);
        bus.dma_hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_ack",   bus.dma_hold_ack, 0);
            check("abort_stall_clr", bus.cpu_stall, 0);
        end
        check("abort_cnt", bus.grant_cnt, 2);
        bus.cpu_busy = 1'b0;

        // ---------------- reset mid-GRANT ----------------
        bus.dma_hold = 1'b1;
        tick();
        tick();
        check("mid_ack", bus.dma_hold_ack, 1);
        bus.dma_we = 1'b1; bus.dma_addr = 32'h300; bus.dma_wd = 32'h0BAD_0BAD;
        bus.cpu_we = 1'b1; bus.cpu_addr = 32'h200; bus.cpu_wd = 32'h7777_0000;
        #2;
        rst = 1'b1;
        #1;
        check("mrst_ack",      bus.dma_hold_ack, 0);
        check("mrst_stall",    bus.cpu_stall,    0);
        check("mrst_mem_we",   bus.mem_we,       1);
        check("mrst_mem_addr", bus.mem_addr,     32'h200);
        check("mrst_mem_wd",   bus.mem_wd,       32'h7777_0000);
        check("mrst_dma_rd",   bus.dma_rd,       0);
        check("mrst_cnt",      bus.grant_cnt,    0);
        bus.cpu_we = 1'b0;
        #1;
        check("mrst_mem_we_follow", bus.mem_we, 0);
        bus.dma_hold = 1'b0; bus.dma_we = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // ---------------- back-to-back ----------------
        bus.dma_hold = 1'b1;                  // cycle 0
        tick();                               // 1 DRAIN
        tick();                               // 2 GRANT
        check("b2b_c2_ack", bus.dma_hold_ack, 1);
        tick();                               // 3 GRANT
        check("b2b_c3_ack", bus.dma_hold_ack, 1);
        bus.dma_hold = 1'b0;
        tick();                               // 4 RELEASE
        check("b2b_c4_ack", bus.dma_hold_ack, 0);
        bus.dma_hold = 1'b1;
        tick();                               // 5 IDLE
        check("b2b_c5_ack", bus.dma_hold_ack, 0);
        check("b2b_c5_stall", bus.cpu_stall, 0);
        tick();                               // 6 DRAIN
        check("b2b_c6_ack", bus.dma_hold_ack, 0);
        tick();                               // 7 GRANT
        check("b2b_c7_ack", bus.dma_hold_ack, 1);
        bus.dma_hold = 1'b0;
        tick();
        tick();
        check("b2b_cnt", bus.grant_cnt, 2);

        // ---------------- long hold / timeout ----------------
        bus.dma_hold = 1'b1;                  // cycle 0
        for (int c = 1; c <= 20; c++) begin
            tick();
`ifdef DMA_BUS_ARBITER_TIMEOUT_EN
            exp_ack = (c >= 2) && (c <= 9);
            exp_err = (c >= 10);
`else
            exp_ack = (c >= 2);
            exp_err = 1'b0;
`endif
            check($sformatf("to_ack_c%0d", c), bus.dma_hold_ack, exp_ack);
            check($sformatf("to_err_c%0d", c), bus.timeout_err,  exp_err);
        end
`ifdef DMA_BUS_ARBITER_TIMEOUT_EN
        check("to_lock_stall", bus.cpu_stall, 0);
`else
        check("to_hold_stall", bus.cpu_stall, 1);
`endif
        bus.dma_hold = 1'b0;
        tick();
        tick();
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check("to_err_clr", bus.timeout_err, 0);
`ifdef DMA_BUS_ARBITER_TIMEOUT_EN
        check("to_cnt", bus.grant_cnt, 2);
`else
        check("to_cnt", bus.grant_cnt, 3);
`endif
        check("to_final_ack", bus.dma_hold_ack, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
